inst_fetch_arb: RTL and testbench

INST_FETCH_ARB -- requirements
Module: inst_fetch_arb

---
 rtl/inst_fetch_arb_pkg.sv | 19 +
 rtl/ravenoc_pkg.sv | 58 +++++
 rtl/inst_arb_fifo.sv | 58 +++++
 rtl/inst_fetch_arb.sv | 163 ++++++++++++++++
 tb/tb_inst_fetch_arb.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_arb_pkg.sv
// Shared mpsoc definitions for the instruction-fetch arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a (types and constants only).
package inst_fetch_arb_pkg;

  localparam int IFA_NUM_REQ  = 2;
  localparam int IFA_OT_DEPTH = 4;

  typedef enum logic {
    ARB     = 1'b0,
    AR_WAIT = 1'b1
  } ifa_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ravenoc_pkg.sv
// Shared AXI4 fabric types used by every master/slave on the NoC.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ravenoc_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    axi_burst_t              awburst;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    axi_burst_t              arburst;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    axi_resp_t             bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    axi_resp_t             rresp;
    logic                  rlast;
    logic                  rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/inst_arb_fifo.sv
// In-order sync FIFO holding the requester index of each outstanding read.
// Latency: head visible combinationally on data_o; a push reaches the head one cycle later.
// Backpressure: full_o/empty_o come from the registered count; push when full or pop when empty is ignored.
module inst_arb_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  // Pointers wrap naturally (power-of-two depth); simultaneous push/pop keeps the count.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_ONE;
      if (pop_ok)  rd_q <= rd_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/inst_fetch_arb.sv
// Round-robin arbiter merging instruction fetches onto one AXI read port, returning beats in order.
// Latency: AR issued combinationally in the request cycle; R beat routed to its requester the same cycle.
// Backpressure: AR held until arready; no new AR while OT_DEPTH reads are outstanding; R is always accepted.
module inst_fetch_arb
  import ravenoc_pkg::*;
  import inst_fetch_arb_pkg::*;
#(
  parameter int NUM_REQ  = IFA_NUM_REQ,
  parameter int OT_DEPTH = IFA_OT_DEPTH
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [NUM_REQ-1:0][31:0] addr_i,
  input  logic [NUM_REQ-1:0]       req_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       rvalid_o,
  output logic [NUM_REQ-1:0][31:0] rdata_o,
  output logic                     err_o,
  output s_axi_mosi_t              m_axi_mosi,
  input  s_axi_miso_t              m_axi_miso
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  ifa_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic [IDX_W-1:0] sel_idx;
  logic             arvalid;
  logic [31:0]      araddr;
  logic             ar_hs;
  logic             pop;
  logic [IDX_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_miso;

  // Fabric fields this read-only master never looks at.
  assign unused_miso = ^{m_axi_miso.awready, m_axi_miso.wready, m_axi_miso.bid, m_axi_miso.bresp,
                         m_axi_miso.bvalid, m_axi_miso.rid, m_axi_miso.rlast};

  // Round-robin pick: first active requester at or after the pointer (descending loop, lowest offset wins).
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[IDX_W'(idx)]) begin
        any_req = 1'b1;
        cand    = IDX_W'(idx);
      end
    end
  end

  // AR FSM: issue straight from ARB, lock winner and address in AR_WAIT until arready.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    rr_d    = rr_q;
    arvalid = 1'b0;
    araddr  = '0;
    sel_idx = cand;
    case (state_q)
      ARB: begin
        if (any_req && !fifo_full) begin
          arvalid = 1'b1;
          araddr  = addr_i[cand];
          if (!m_axi_miso.arready) begin
            state_d = AR_WAIT;
            win_d   = cand;
            addr_d  = addr_i[cand];
          end
        end
      end
      AR_WAIT: begin
        arvalid = 1'b1;
        araddr  = addr_q;
        sel_idx = win_q;
        if (m_axi_miso.arready) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    ar_hs = arvalid && m_axi_miso.arready;
    if (ar_hs) rr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_ONE;
  end

  // Grant is the AR handshake, shown only on the winner's bit.
  always_comb begin
    gnt_o = '0;
    if (ar_hs) gnt_o[sel_idx] = 1'b1;
  end

  // Single-beat 32-bit INCR reads on ID 0; write channels stay idle.
  always_comb begin
    m_axi_mosi         = '0;
    m_axi_mosi.arvalid = arvalid;
    m_axi_mosi.araddr  = araddr;
    m_axi_mosi.arlen   = 8'd0;
    m_axi_mosi.arsize  = 3'd2;
    m_axi_mosi.arburst = INCR;
    m_axi_mosi.arid    = '0;
    m_axi_mosi.rready  = 1'b1;
  end

  // R routing: head of the order FIFO owns the beat; stray beats and error responses set the sticky flag.
  always_comb begin
    pop      = m_axi_miso.rvalid && !fifo_empty;
    rvalid_o = '0;
    rdata_o  = '0;
    err_d    = err_q;
    if (pop) begin
      rvalid_o[head] = 1'b1;
      rdata_o[head]  = m_axi_miso.rdata;
      if (m_axi_miso.rresp != OKAY) err_d = 1'b1;
    end
    if (m_axi_miso.rvalid && fifo_empty) err_d = 1'b1;
  end

  // State, pointer, lock and error registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ARB;
      rr_q    <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

  inst_arb_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OT_DEPTH)
  ) u_order_fifo (
    .clk     (clk),
    .arst    (arst),
    .push_i  (ar_hs),
    .data_i  (sel_idx),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_inst_fetch_arb.sv
// Bench for inst_fetch_arb: directed fetch scenarios, a queue-based reference model, literal spot checks.
// Latency: model expects AR/grant and R routing in the same cycle as the stimulus.
// Backpressure: arready and R beats are driven directly by the stimulus.
module tb_inst_fetch_arb;
  import ravenoc_pkg::*;

  localparam int NUM_REQ  = 2;
  localparam int OT_DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     arst;
  logic [NUM_REQ-1:0][31:0] addr_i;
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [NUM_REQ-1:0]       rvalid_o;
  logic [NUM_REQ-1:0][31:0] rdata_o;
  logic                     err_o;
  s_axi_mosi_t              mosi;
  s_axi_miso_t              miso;

  logic        arready;
  logic        rv;
  logic [31:0] rd;
  logic [1:0]  rs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    miso         = '0;
    miso.arready = arready;
    miso.rvalid  = rv;
    miso.rdata   = rd;
    miso.rresp   = axi_resp_t'(rs);
    miso.rlast   = rv;
  end

  inst_fetch_arb #(.NUM_REQ(NUM_REQ), .OT_DEPTH(OT_DEPTH)) dut (
    .clk        (clk),
    .arst       (arst),
    .addr_i     (addr_i),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .m_axi_mosi (mosi),
    .m_axi_miso (miso)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: queue of owners of outstanding reads, RR pointer, pending (locked) AR, sticky error.
  int                       q[$];
  int                       m_rr = 0;
  bit                       m_pend = 0;
  int                       m_pend_who = 0;
  logic [31:0]              m_pend_addr = '0;
  bit                       m_err = 0;
  bit                       e_arv;
  bit                       e_hs;
  bit                       n_err;
  int                       who;
  int                       h;
  logic [31:0]              e_addr;
  logic [NUM_REQ-1:0]       e_gnt;
  logic [NUM_REQ-1:0]       e_rv;
  logic [NUM_REQ-1:0][31:0] e_rd;

  always @(negedge clk) begin
    if (arst) begin
      q.delete();
      m_rr = 0; m_pend = 0; m_err = 0;
      chk("m_rst_gnt", gnt_o, 0);
      chk("m_rst_arvalid", mosi.arvalid, 0);
      chk("m_rst_rvalid", rvalid_o, 0);
      chk("m_rst_rdata", rdata_o, 0);
      chk("m_rst_err", err_o, 0);
    end else begin
      e_arv = 0; who = 0; e_addr = '0; n_err = 0;
      if (m_pend) begin
        e_arv = 1; who = m_pend_who; e_addr = m_pend_addr;
      end else if (q.size() < OT_DEPTH) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int c;
          c = (m_rr + k) % NUM_REQ;
          if (req_i[c] && !e_arv) begin
            e_arv = 1; who = c; e_addr = addr_i[c];
          end
        end
      end
      e_hs  = e_arv && arready;
      e_gnt = '0;
      if (e_hs) e_gnt[who] = 1'b1;
      e_rv = '0; e_rd = '0;
      if (rv) begin
        if (q.size() > 0) begin
          h = q.pop_front();
          e_rv[h] = 1'b1;
          e_rd[h] = rd;
          if (rs != 2'b00) n_err = 1;
        end else begin
          n_err = 1;
        end
      end
      chk("m_gnt", gnt_o, e_gnt);
      chk("m_arvalid", mosi.arvalid, e_arv);
      if (e_arv) begin
        chk("m_araddr", mosi.araddr, e_addr);
        chk("m_arfields", {mosi.arlen, mosi.arsize, mosi.arburst, mosi.arid},
            {8'd0, 3'd2, 2'b01, 4'd0});
      end
      chk("m_idle_w", {mosi.awvalid, mosi.wvalid, mosi.bready, mosi.rready}, 4'b0001);
      chk("m_rvalid", rvalid_o, e_rv);
      chk("m_rdata", rdata_o, e_rd);
      chk("m_err", err_o, m_err);
      if (e_hs) begin
        q.push_back(who);
        m_rr = (who + 1) % NUM_REQ;
        m_pend = 0;
      end else if (e_arv) begin
        m_pend = 1; m_pend_who = who; m_pend_addr = e_addr;
      end
      if (n_err) m_err = 1;
    end
  end

  task automatic cyc(input logic [NUM_REQ-1:0] rq, input logic ar, input logic v,
                     input logic [31:0] d, input logic [1:0] s);
    @(posedge clk); #1;
    req_i = rq; arready = ar; rv = v; rd = d; rs = s;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req_i = '0; arready = 1'b0; rv = 1'b0; rd = '0; rs = 2'b00; arst = 1'b1;
    @(negedge clk); #1;
    chk("rst_err", err_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_arvalid", mosi.arvalid, 0);
    @(posedge clk); #1;
    arst = 1'b0;
  endtask

  initial begin
    arst = 1'b1; req_i = '0; arready = 1'b0; rv = 1'b0; rd = '0; rs = 2'b00; addr_i = '0;
    do_reset();

    // Single fetch from requester 0, then its beat.
    addr_i[0] = 32'h100;
    cyc(2'b01, 1, 0, 0, 0);
    chk("t030_gnt", gnt_o, 2'b01);
    chk("t030_araddr", mosi.araddr, 32'h100);
    cyc(2'b00, 1, 1, 32'hDEAD, 0);
    chk("t030_rvalid", rvalid_o, 2'b01);
    chk("t030_rdata0", rdata_o[0], 32'hDEAD);
    chk("t030_rdata1", rdata_o[1], 0);

    // Both requesting: grants alternate from a fresh pointer.
    do_reset();
    addr_i[0] = 32'h1000; addr_i[1] = 32'h2000;
    cyc(2'b11, 1, 0, 0, 0); chk("t031_g0", gnt_o, 2'b01);
    cyc(2'b11, 1, 0, 0, 0); chk("t031_g1", gnt_o, 2'b10);
    chk("t031_addr1", mosi.araddr, 32'h2000);
    cyc(2'b11, 1, 0, 0, 0); chk("t031_g2", gnt_o, 2'b01);
    cyc(2'b11, 1, 0, 0, 0); chk("t031_g3", gnt_o, 2'b10);
    for (int i = 0; i < 4; i++) cyc(2'b00, 1, 1, 32'h10 + i, 0);
    chk("t031_last_rv", rvalid_o, 2'b10);

    // arready stalled three cycles; requester 0 drops its request while locked.
    addr_i[0] = 32'h200; addr_i[1] = 32'h300;
    cyc(2'b11, 0, 0, 0, 0);
    chk("t032_arv0", mosi.arvalid, 1); chk("t032_addr0", mosi.araddr, 32'h200); chk("t032_g0", gnt_o, 0);
    cyc(2'b11, 0, 0, 0, 0);
    chk("t032_addr1", mosi.araddr, 32'h200); chk("t032_g1", gnt_o, 0);
    addr_i[0] = 32'hBAD0;
    cyc(2'b10, 0, 0, 0, 0);
    chk("t032_addr2", mosi.araddr, 32'h200); chk("t032_g2", gnt_o, 0);
    cyc(2'b10, 1, 0, 0, 0);
    chk("t032_gnt", gnt_o, 2'b01); chk("t032_addr3", mosi.araddr, 32'h200);
    cyc(2'b10, 1, 0, 0, 0);
    chk("t032_gnt_r1", gnt_o, 2'b10); chk("t032_addr_r1", mosi.araddr, 32'h300);
    cyc(2'b00, 1, 1, 32'h11, 0); chk("t025_route", rvalid_o, 2'b01);
    cyc(2'b00, 1, 1, 32'h22, 0); chk("t032_route1", rvalid_o, 2'b10);

    // Four outstanding reads fill the order FIFO.
    addr_i[0] = 32'h400;
    for (int i = 0; i < 4; i++) begin
      cyc(2'b01, 1, 0, 0, 0);
      chk("t033_fill", gnt_o, 2'b01);
    end
    cyc(2'b01, 1, 0, 0, 0);
    chk("t033_full_gnt", gnt_o, 0); chk("t033_full_arv", mosi.arvalid, 0);
    cyc(2'b01, 1, 1, 32'h55, 0);
    chk("t033_pop_gnt", gnt_o, 0); chk("t033_pop_arv", mosi.arvalid, 0); chk("t033_pop_rv", rvalid_o, 2'b01);
    cyc(2'b01, 1, 0, 0, 0);
    chk("t033_unblock", gnt_o, 2'b01);
    for (int i = 0; i < 4; i++) cyc(2'b00, 1, 1, 32'h60 + i, 0);

    // Grants 0,1,0 with the third grant overlapping the first beat.
    cyc(2'b01, 1, 0, 0, 0); chk("t034_g0", gnt_o, 2'b01);
    cyc(2'b10, 1, 0, 0, 0); chk("t034_g1", gnt_o, 2'b10);
    cyc(2'b01, 1, 1, 32'hA, 0);
    chk("t034_g2", gnt_o, 2'b01); chk("t034_rvA", rvalid_o, 2'b01); chk("t034_dA", rdata_o[0], 32'hA);
    cyc(2'b00, 1, 1, 32'hB, 0); chk("t034_rvB", rvalid_o, 2'b10); chk("t034_dB", rdata_o[1], 32'hB);
    cyc(2'b00, 1, 1, 32'hC, 0); chk("t034_rvC", rvalid_o, 2'b01); chk("t034_dC", rdata_o[0], 32'hC);
    chk("t034_noerr", err_o, 0);

    // Stray beat, sticky error, reset, error response, mid-transaction reset.
    cyc(2'b00, 1, 1, 32'h77, 0); chk("t035_drop", rvalid_o, 0);
    cyc(2'b00, 1, 0, 0, 0); chk("t035_err", err_o, 1);
    cyc(2'b00, 1, 0, 0, 0); chk("t035_err_held", err_o, 1);
    do_reset();
    cyc(2'b01, 1, 0, 0, 0); chk("t035_g", gnt_o, 2'b01);
    cyc(2'b00, 1, 1, 32'h99, 2'b10);
    chk("t035_slverr_rv", rvalid_o, 2'b01); chk("t035_slverr_d", rdata_o[0], 32'h99);
    cyc(2'b00, 1, 0, 0, 0); chk("t035_slverr_err", err_o, 1);
    do_reset();
    cyc(2'b01, 1, 0, 0, 0);
    cyc(2'b01, 1, 0, 0, 0);
    do_reset();
    cyc(2'b00, 1, 1, 32'h5, 0); chk("t027_flushed", rvalid_o, 0);
    cyc(2'b00, 1, 0, 0, 0); chk("t027_err", err_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
